// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, fetch FSM states, opcodes.
// Pure declarations, no logic and no latency.
// No backpressure: nothing here is clocked.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int ILEN     = 32;
    localparam int OPCODE_W = 7;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Base-ISA major opcodes seen by the control unit
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_t;

    // One buffered instruction: where it came from and what it is
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Instruction buffer between the imem response and decode, with flush.
// Latency: a push is visible at the head one cycle later; head is read from flops.
// Backpressure: head held while pop_rdy is low; pushes refused when full or flushing.
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_vld,
    input  fetch_entry_t                 push_dat,
    output logic                         pop_vld,
    input  logic                         pop_rdy,
    output fetch_entry_t                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush beats both push and pop so a redirect leaves the buffer empty
    assign do_pop  = pop_rdy && (count != '0) && !flush;
    assign do_push = push_vld && !flush && (count != CNT_W'(DEPTH));

    assign pop_vld = (count != '0);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents only matter where count says they are valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch: issues word reads to imem, buffers responses, feeds decode.
// Latency: response in cycle N appears on inst_* in cycle N+1; one request in flight.
// Backpressure: stops requesting when buffer plus in-flight reaches depth; redirect flushes.
// Optional RISCV_FETCH_MISALIGN_CHECK_EN: sticky misalign_err on unaligned redirect targets.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [ILEN-1:0]     imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_target,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [ILEN-1:0]     inst_data,
    output logic [XLEN-1:0]     inst_pc,
    output logic [OPCODE_W-1:0] inst_opcode,
    output logic                misalign_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_addr_q;
    logic             outstanding;
    logic             kill;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;
    logic [CNT_W:0]   cnt_after;
    logic             req_ok;
    logic             req_fire;
    logic             rsp_take;
    logic             push;
    logic             pop_fire;
    logic             space_after;
    logic [XLEN-1:0]  target_aligned;
    fetch_entry_t     push_dat;
    fetch_entry_t     head;

    assign target_aligned = word_align(redirect_target);

    // Entries held plus the one in flight must leave room for the next response
    assign inflight = {1'b0, fifo_count} + (CNT_W+1)'(outstanding);
    assign req_ok   = !outstanding && !redirect_valid &&
                      (inflight < (CNT_W+1)'(FIFO_DEPTH));

    assign imem_req_valid = !rst && req_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight are stray and ignored
    assign rsp_take = imem_rsp_valid && outstanding;
    assign push     = rsp_take && !kill && !redirect_valid;
    assign pop_fire = inst_valid && inst_ready && !redirect_valid;

    assign cnt_after   = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop_fire);
    assign space_after = cnt_after < (CNT_W+1)'(FIFO_DEPTH);

    assign push_dat.pc   = req_addr_q;
    assign push_dat.data = imem_rsp_data;

    // PC, in-flight and kill tracking; a redirect orphans whatever is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_addr_q  <= RESET_PC;
            outstanding <= 1'b0;
            kill        <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= target_aligned;
            outstanding <= (outstanding && !imem_rsp_valid) || req_fire;
            kill        <= (outstanding && !imem_rsp_valid) || req_fire;
        end else if (req_fire) begin
            pc          <= pc + PC_STEP;
            req_addr_q  <= pc;
            outstanding <= 1'b1;
            kill        <= 1'b0;
        end else if (rsp_take) begin
            outstanding <= 1'b0;
            kill        <= 1'b0;
        end
    end

    // Fetch sequencing: idle until a request may go out, wait for its data
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            state <= FETCH_IDLE;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (req_fire) begin
                        state <= FETCH_WAIT;
                    end else if (req_ok) begin
                        state <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (req_fire) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (rsp_take) begin
                        state <= space_after ? FETCH_REQ : FETCH_IDLE;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_vld  (inst_valid),
        .pop_rdy  (inst_ready),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    assign inst_data   = head.data;
    assign inst_pc     = head.pc;
    assign inst_opcode = head.data[OPCODE_W-1:0];

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    // Remember any redirect to an unaligned target until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a 1-cycle-latency imem model.
// Latency: expectations are written per cycle against the hand-derived timeline.
// Backpressure: exercises decode stall, redirects, wrap and mid-transaction reset.
module tb_riscv_fetch_unit;
    import riscv_pkg::*;

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [6:0]  inst_opcode;
    logic        misalign_err;

    int   checks   = 0;
    int   failures = 0;
    logic auto_rsp;

    riscv_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_opcode     (inst_opcode),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address bits above the opcode, opcode chosen by addr[4:2]
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [6:0] opc;
        case (a[4:2])
            3'd0:    opc = OPC_LUI;
            3'd1:    opc = OPC_AUIPC;
            3'd2:    opc = OPC_JAL;
            3'd3:    opc = OPC_JALR;
            3'd4:    opc = OPC_BRANCH;
            3'd5:    opc = OPC_LOAD;
            3'd6:    opc = OPC_STORE;
            default: opc = OPC_OP_IMM;
        endcase
        return {a[24:0], opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the imem model answers an accepted request one cycle later
    task automatic step();
        logic        fired;
        logic [31:0] faddr;
        fired = imem_req_valid && imem_req_ready;
        faddr = imem_req_addr;
        @(posedge clk);
        #2;
        if (auto_rsp) begin
            imem_rsp_valid = fired;
            imem_rsp_data  = fired ? word(faddr) : 32'h0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        inst_ready      = 1'b1;
        auto_rsp        = 1'b1;

        // Reset state
        step();
        step();
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);

        // First cycle out of reset requests RESET_PC
        rst = 1'b0;
        settle();
        chk1("c0_req_valid", imem_req_valid, 1'b1);
        chk("c0_req_addr", imem_req_addr, 32'h0);

        step(); // C1: response for 0x0 arriving
        chk1("c1_req_valid", imem_req_valid, 1'b0);
        chk1("c1_inst_valid", inst_valid, 1'b0);

        step(); // C2
        chk1("c2_inst_valid", inst_valid, 1'b1);
        chk("c2_inst_pc", inst_pc, 32'h0);
        chk("c2_inst_data", inst_data, word(32'h0));
        chk("c2_opcode", {25'b0, inst_opcode}, {25'b0, OPC_LUI});
        chk("c2_req_addr", imem_req_addr, 32'h4);
        chk1("c2_req_valid", imem_req_valid, 1'b1);

        step(); // C3
        chk1("c3_inst_valid", inst_valid, 1'b0);

        step(); // C4
        chk("c4_inst_pc", inst_pc, 32'h4);
        chk("c4_opcode", {25'b0, inst_opcode}, {25'b0, OPC_AUIPC});
        chk("c4_req_addr", imem_req_addr, 32'h8);

        step(); // C5
        step(); // C6
        chk("c6_inst_pc", inst_pc, 32'h8);
        inst_ready = 1'b0;
        settle();
        chk1("c6_req_valid", imem_req_valid, 1'b1);
        chk("c6_req_addr", imem_req_addr, 32'hC);

        step(); // C7: one buffered, 0xC in flight
        chk1("c7_req_valid", imem_req_valid, 1'b0);
        chk("c7_inst_pc", inst_pc, 32'h8);

        step(); // C8: buffer full
        chk1("c8_req_valid", imem_req_valid, 1'b0);
        chk1("c8_inst_valid", inst_valid, 1'b1);
        chk("c8_inst_pc", inst_pc, 32'h8);
        chk("c8_inst_data", inst_data, word(32'h8));

        step(); // C9
        chk1("c9_req_valid", imem_req_valid, 1'b0);
        chk("c9_inst_pc", inst_pc, 32'h8);
        inst_ready = 1'b1;

        step(); // C10: second buffered entry follows immediately
        chk1("c10_inst_valid", inst_valid, 1'b1);
        chk("c10_inst_pc", inst_pc, 32'hC);
        chk("c10_opcode", {25'b0, inst_opcode}, {25'b0, OPC_JALR});
        chk1("c10_req_valid", imem_req_valid, 1'b1);
        chk("c10_req_addr", imem_req_addr, 32'h10);

        step(); // C11
        chk1("c11_inst_valid", inst_valid, 1'b0);

        step(); // C12
        chk("c12_inst_pc", inst_pc, 32'h10);
        chk("c12_req_addr", imem_req_addr, 32'h14);
        auto_rsp = 1'b0;

        step(); // C13: 0x14 in flight, redirect to 0x100
        chk1("c13_inst_valid", inst_valid, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        settle();
        chk1("c13_req_valid_redir", imem_req_valid, 1'b0);

        step(); // C14: late response for the killed 0x14 request
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(32'h14);
        auto_rsp       = 1'b1;
        settle();
        chk1("c14_req_valid", imem_req_valid, 1'b0);
        chk1("c14_inst_valid", inst_valid, 1'b0);

        step(); // C15
        chk1("c15_inst_valid_killed", inst_valid, 1'b0);
        chk1("c15_req_valid", imem_req_valid, 1'b1);
        chk("c15_req_addr", imem_req_addr, 32'h100);

        step(); // C16
        chk1("c16_inst_valid", inst_valid, 1'b0);

        step(); // C17
        chk("c17_inst_pc", inst_pc, 32'h100);
        chk("c17_inst_data", inst_data, word(32'h100));

        step(); // C18: redirect coincides with response for 0x104
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        settle();
        chk1("c18_req_valid", imem_req_valid, 1'b0);

        step(); // C19
        redirect_valid = 1'b0;
        settle();
        chk1("c19_inst_valid_dropped", inst_valid, 1'b0);
        chk("c19_req_addr", imem_req_addr, 32'h200);

        step(); // C20: back-to-back redirects, last wins
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        step(); // C21
        redirect_target = 32'h400;
        step(); // C22
        redirect_valid = 1'b0;
        settle();
        chk1("c22_inst_valid", inst_valid, 1'b0);
        chk1("c22_req_valid", imem_req_valid, 1'b1);
        chk("c22_req_addr", imem_req_addr, 32'h400);

        step(); // C23
        chk1("c23_inst_valid", inst_valid, 1'b0);

        step(); // C24: redirect to unaligned target while decode pops
        chk("c24_inst_pc", inst_pc, 32'h400);
        redirect_valid  = 1'b1;
        redirect_target = 32'h503;

        step(); // C25
        redirect_valid = 1'b0;
        settle();
        chk1("c25_inst_valid_flushed", inst_valid, 1'b0);
        chk("c25_req_addr_aligned", imem_req_addr, 32'h500);
        chk1("c25_misalign", misalign_err, MIS_EXP);

        step(); // C26
        step(); // C27
        chk("c27_inst_pc", inst_pc, 32'h500);
        chk1("c27_misalign_sticky", misalign_err, MIS_EXP);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;

        step(); // C28
        redirect_valid = 1'b0;
        settle();
        chk1("c28_req_valid", imem_req_valid, 1'b1);
        chk("c28_req_addr", imem_req_addr, 32'hFFFF_FFFC);

        step(); // C29
        step(); // C30: PC wrapped
        chk("c30_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("c30_opcode", {25'b0, inst_opcode}, {25'b0, OPC_OP_IMM});
        chk("c30_req_addr_wrap", imem_req_addr, 32'h0);
        auto_rsp = 1'b0;

        step(); // C31: reset with request to 0x0 in flight
        rst = 1'b1;
        settle();
        chk1("c31_req_valid_in_rst", imem_req_valid, 1'b0);

        step(); // C32: stale response after reset, memory stalling
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        chk1("c32_req_valid", imem_req_valid, 1'b1);
        chk("c32_req_addr", imem_req_addr, 32'h0);
        chk1("c32_inst_valid", inst_valid, 1'b0);
        chk1("c32_misalign_cleared", misalign_err, 1'b0);

        step(); // C33
        chk1("c33_inst_valid_stale", inst_valid, 1'b0);
        chk1("c33_req_valid_held", imem_req_valid, 1'b1);
        chk("c33_req_addr_held", imem_req_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
